// File: rtl/encrypter_pipe_pkg.sv
// Shared constants for the encrypter pipeline:
// default widths, FSM state encoding and a fill-to-state helper.
package encrypter_pipe_pkg;

   localparam int ENCRYPTER_WIDTH    = 16;
   localparam int KEY_ROTATION_WIDTH = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BUSY = 3'd1,
      S_FULL = 3'd2,
      S_PROG = 3'd3,
      S_ERR  = 3'd4
   } state_e;

   function automatic state_e fill_state(input logic [1:0] f);
      unique case (f)
         2'd0:    return S_IDLE;
         2'd1:    return S_BUSY;
         default: return S_FULL;
      endcase
   endfunction

endpackage

// File: rtl/encrypter_pipe_fifo.sv
// Two-entry output FIFO; entry 0 is always the head.
// Pushing into a full FIFO is only honoured together with a pop.
module enc_out_fifo #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic [1:0]   o_fill
);

   logic [W-1:0] r_mem0;
   logic [W-1:0] r_mem1;
   logic [1:0]   r_fill;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_pop && (r_fill != 2'd0);
   assign w_push = i_push && ((r_fill != 2'd2) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem0 <= '0;
         r_mem1 <= '0;
         r_fill <= 2'd0;
      end else if (i_flush) begin
         r_fill <= 2'd0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10: begin
               if (r_fill == 2'd0) r_mem0 <= i_din;
               else                r_mem1 <= i_din;
               r_fill <= r_fill + 2'd1;
            end
            2'b01: begin
               r_mem0 <= r_mem1;
               r_fill <= r_fill - 2'd1;
            end
            2'b11: begin
               if (r_fill == 2'd1) begin
                  r_mem0 <= i_din;
               end else begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= i_din;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dout = r_mem0;
   assign o_fill = r_fill;

endmodule

// File: rtl/encrypter_pipe.sv
// Rotate/XOR stream encrypter with rolling key, key programming,
// error flush and a 2-deep output buffer.
module encrypter_pipe
   import encrypter_pipe_pkg::*;
#(
   parameter int                DATA_W   = ENCRYPTER_WIDTH,
   parameter int                ROT_W    = KEY_ROTATION_WIDTH,
   parameter logic [DATA_W-1:0] KEY_INIT = '0,
   parameter bit                KEY_ROLL = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] dataIn,
   input  logic [ROT_W-1:0]  rot_offset,
   input  logic              rdyIn,
   output logic              reqIn,
   input  logic              prog,
   input  logic              decrypt,
   input  logic              error,
   output logic [DATA_W-1:0] dataOut,
   output logic              reqOut,
   input  logic              rdyOut,
   output logic [2:0]        state,
   output logic [DATA_W-1:0] key,
   output logic [1:0]        fill
);

   if (ROT_W != $clog2(DATA_W) || DATA_W < 4) begin : g_chk
      $error("encrypter_pipe: bad DATA_W/ROT_W");
   end

   state_e            r_state;
   logic [DATA_W-1:0] r_key;
   logic [1:0]        w_fill;
   logic [1:0]        w_fill_nx;
   logic              w_run;
   logic              w_xfer;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_mix;
   logic [DATA_W-1:0] w_enc;
   logic [DATA_W-1:0] w_rr;
   logic [DATA_W-1:0] w_dec;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_roll;

   assign w_mix  = dataIn ^ r_key;
   assign w_enc  = (w_mix << rot_offset)
                 | (w_mix >> (DATA_W - int'(rot_offset)));
   assign w_rr   = (dataIn >> rot_offset)
                 | (dataIn << (DATA_W - int'(rot_offset)));
   assign w_dec  = w_rr ^ r_key;
   assign w_word = decrypt ? w_dec : w_enc;
   assign w_roll = {r_key[DATA_W-2:0], r_key[DATA_W-1]};

   // Anything outside the four running states flushes and blocks traffic.
   assign w_run  = !error && (r_state inside {S_IDLE, S_BUSY, S_FULL, S_PROG});
   assign reqIn  = (r_state == S_IDLE) || (r_state == S_BUSY);
   assign reqOut = (w_fill != 2'd0) && (r_state != S_ERR);
   assign w_xfer = rdyIn && reqIn && w_run;
   assign w_push = w_xfer && !prog;
   assign w_pop  = reqOut && rdyOut && w_run;

   always_comb begin
      w_fill_nx = w_fill;
      if (w_push && !w_pop)      w_fill_nx = w_fill + 2'd1;
      else if (!w_push && w_pop) w_fill_nx = w_fill - 2'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_key   <= KEY_INIT;
      end else if (error) begin
         r_state <= S_ERR;
      end else begin
         unique case (r_state)
            S_IDLE, S_BUSY, S_FULL, S_PROG: begin
               if (w_xfer && prog) r_state <= S_PROG;
               else                r_state <= fill_state(w_fill_nx);
            end
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_ERR;
         endcase
         if (w_xfer && prog)             r_key <= dataIn;
         else if (w_push && KEY_ROLL) r_key <= w_roll;
      end
   end

   enc_out_fifo #(.W(DATA_W)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (!w_run),
      .i_din   (w_word),
      .o_dout  (dataOut),
      .o_fill  (w_fill)
   );

   assign state = r_state;
   assign key   = r_key;
   assign fill  = w_fill;

endmodule

// File: tb/tb_encrypter_pipe.sv
// Directed bench for encrypter_pipe: encrypt/decrypt vectors,
// buffering, back-to-back, error flush and async reset.
module tb_encrypter_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] dataIn = '0;
   logic [3:0]  rot_offset = '0;
   logic        rdyIn = 1'b0;
   logic        reqIn;
   logic        prog = 1'b0;
   logic        decrypt = 1'b0;
   logic        error = 1'b0;
   logic [15:0] dataOut;
   logic        reqOut;
   logic        rdyOut = 1'b0;
   logic [2:0]  state;
   logic [15:0] key;
   logic [1:0]  fill;

   int n_cmp = 0;
   int n_bad = 0;

   encrypter_pipe dut (
      .clk        (clk),
      .reset      (reset),
      .dataIn     (dataIn),
      .rot_offset (rot_offset),
      .rdyIn      (rdyIn),
      .reqIn      (reqIn),
      .prog       (prog),
      .decrypt    (decrypt),
      .error      (error),
      .dataOut    (dataOut),
      .reqOut     (reqOut),
      .rdyOut     (rdyOut),
      .state      (state),
      .key        (key),
      .fill       (fill)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired");
      $fatal(1, "watchdog");
   end

   task automatic idle_in();
      rdyIn = 0; prog = 0; decrypt = 0; error = 0;
      dataIn = '0; rot_offset = '0;
   endtask

   task automatic do_reset();
      reset = 0;
      #2;
      reset = 1;
      @(negedge clk);
   endtask

   task automatic load_key(input logic [15:0] k);
      prog = 1; rdyIn = 1; dataIn = k;
      @(negedge clk);
      idle_in();
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] d, input logic [3:0] r,
                       input logic dec);
      rdyIn = 1; dataIn = d; rot_offset = r; decrypt = dec;
      @(negedge clk);
      idle_in();
   endtask

   task automatic test_reset();
      idle_in();
      rdyOut = 0;
      reset = 0;
      repeat (2) @(negedge clk);
      reset = 1;
      @(negedge clk);
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL rst_fill: got %0d want 0", fill); end
      n_cmp++; if (reqOut !== 1'b0) begin n_bad++; $display("FAIL rst_reqOut: got %b want 0", reqOut); end
      n_cmp++; if (reqIn !== 1'b1) begin n_bad++; $display("FAIL rst_reqIn: got %b want 1", reqIn); end
      n_cmp++; if (dataOut !== 16'h0000) begin n_bad++; $display("FAIL rst_dataOut: got %h want 0000", dataOut); end
      n_cmp++; if (key !== 16'h0000) begin n_bad++; $display("FAIL rst_key: got %h want 0000", key); end
   endtask

   task automatic test_encrypt();
      prog = 1; rdyIn = 1; dataIn = 16'hF0F0;
      @(negedge clk);
      idle_in();
      n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL prog_state: got %0d want 3", state); end
      n_cmp++; if (key !== 16'hF0F0) begin n_bad++; $display("FAIL prog_key: got %h want f0f0", key); end
      n_cmp++; if (reqIn !== 1'b0) begin n_bad++; $display("FAIL prog_reqIn: got %b want 0", reqIn); end
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL prog_fill: got %0d want 0", fill); end
      @(negedge clk);
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL prog_exit: got %0d want 0", state); end
      send(16'h1234, 4'd4, 1'b0);
      n_cmp++; if (dataOut !== 16'h2C4E) begin n_bad++; $display("FAIL enc_data: got %h want 2c4e", dataOut); end
      n_cmp++; if (reqOut !== 1'b1) begin n_bad++; $display("FAIL enc_reqOut: got %b want 1", reqOut); end
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL enc_state: got %0d want 1", state); end
      n_cmp++; if (key !== 16'hE1E1) begin n_bad++; $display("FAIL enc_key: got %h want e1e1", key); end
      rdyOut = 1;
      @(negedge clk);
      rdyOut = 0;
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL enc_pop_fill: got %0d want 0", fill); end
      n_cmp++; if (reqOut !== 1'b0) begin n_bad++; $display("FAIL enc_pop_reqOut: got %b want 0", reqOut); end
   endtask

   task automatic test_decrypt();
      do_reset();
      load_key(16'hF0F0);
      send(16'h2C4E, 4'd4, 1'b1);
      n_cmp++; if (dataOut !== 16'h1234) begin n_bad++; $display("FAIL dec_data: got %h want 1234", dataOut); end
      n_cmp++; if (key !== 16'hE1E1) begin n_bad++; $display("FAIL dec_key: got %h want e1e1", key); end
      rdyOut = 1;
      @(negedge clk);
      rdyOut = 0;
      // rot 0 and rot 15 boundaries, buffered back to back
      send(16'h0000, 4'd0, 1'b0);
      send(16'h0001, 4'd15, 1'b0);
      n_cmp++; if (fill !== 2'd2) begin n_bad++; $display("FAIL rot_fill: got %0d want 2", fill); end
      n_cmp++; if (dataOut !== 16'hE1E1) begin n_bad++; $display("FAIL rot0_data: got %h want e1e1", dataOut); end
      n_cmp++; if (key !== 16'h8787) begin n_bad++; $display("FAIL rot_key: got %h want 8787", key); end
      rdyOut = 1;
      @(negedge clk);
      n_cmp++; if (dataOut !== 16'h61E1) begin n_bad++; $display("FAIL rot15_data: got %h want 61e1", dataOut); end
      @(negedge clk);
      rdyOut = 0;
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL rot_drain: got %0d want 0", fill); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      rdyOut = 0;
      rdyIn = 1; dataIn = 16'h1111;
      @(negedge clk);
      dataIn = 16'h2222;
      @(negedge clk);
      dataIn = 16'h3333;
      @(negedge clk);
      n_cmp++; if (fill !== 2'd2) begin n_bad++; $display("FAIL full_fill: got %0d want 2", fill); end
      n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL full_state: got %0d want 2", state); end
      n_cmp++; if (reqIn !== 1'b0) begin n_bad++; $display("FAIL full_reqIn: got %b want 0", reqIn); end
      n_cmp++; if (dataOut !== 16'h1111) begin n_bad++; $display("FAIL full_head: got %h want 1111", dataOut); end
      rdyOut = 1;
      @(negedge clk);
      n_cmp++; if (dataOut !== 16'h2222) begin n_bad++; $display("FAIL pop1_data: got %h want 2222", dataOut); end
      n_cmp++; if (reqIn !== 1'b1) begin n_bad++; $display("FAIL pop1_reqIn: got %b want 1", reqIn); end
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL pop1_state: got %0d want 1", state); end
      @(negedge clk);
      idle_in();
      n_cmp++; if (fill !== 2'd1) begin n_bad++; $display("FAIL pushpop_fill: got %0d want 1", fill); end
      n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL pushpop_state: got %0d want 1", state); end
      n_cmp++; if (dataOut !== 16'h3333) begin n_bad++; $display("FAIL pushpop_data: got %h want 3333", dataOut); end
      @(negedge clk);
      rdyOut = 0;
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL b2b_drain: got %0d want 0", fill); end
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL b2b_idle: got %0d want 0", state); end
   endtask

   task automatic test_error();
      do_reset();
      load_key(16'hF0F0);
      rdyOut = 0;
      send(16'h0001, 4'd0, 1'b0);
      send(16'h0002, 4'd0, 1'b0);
      n_cmp++; if (fill !== 2'd2) begin n_bad++; $display("FAIL err_pre_fill: got %0d want 2", fill); end
      error = 1; rdyIn = 1; rdyOut = 1; dataIn = 16'h0003;
      @(negedge clk);
      n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL err_state: got %0d want 4", state); end
      n_cmp++; if (reqOut !== 1'b0) begin n_bad++; $display("FAIL err_reqOut: got %b want 0", reqOut); end
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL err_fill: got %0d want 0", fill); end
      n_cmp++; if (key !== 16'hC3C3) begin n_bad++; $display("FAIL err_key: got %h want c3c3", key); end
      n_cmp++; if (reqIn !== 1'b0) begin n_bad++; $display("FAIL err_reqIn: got %b want 0", reqIn); end
      @(negedge clk);
      n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL err_hold: got %0d want 4", state); end
      idle_in();
      @(negedge clk);
      rdyOut = 0;
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL err_exit: got %0d want 0", state); end
      n_cmp++; if (reqIn !== 1'b1) begin n_bad++; $display("FAIL err_exit_reqIn: got %b want 1", reqIn); end
   endtask

   task automatic test_async_reset();
      do_reset();
      load_key(16'h00FF);
      rdyOut = 0;
      send(16'hAAAA, 4'd3, 1'b0);
      send(16'h5555, 4'd7, 1'b0);
      #2;
      reset = 0;
      #1;
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL ar_state: got %0d want 0", state); end
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL ar_fill: got %0d want 0", fill); end
      n_cmp++; if (reqOut !== 1'b0) begin n_bad++; $display("FAIL ar_reqOut: got %b want 0", reqOut); end
      n_cmp++; if (dataOut !== 16'h0000) begin n_bad++; $display("FAIL ar_dataOut: got %h want 0000", dataOut); end
      n_cmp++; if (key !== 16'h0000) begin n_bad++; $display("FAIL ar_key: got %h want 0000", key); end
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      n_cmp++; if (reqIn !== 1'b1) begin n_bad++; $display("FAIL ar_reqIn: got %b want 1", reqIn); end
      n_cmp++; if (fill !== 2'd0) begin n_bad++; $display("FAIL ar_post_fill: got %0d want 0", fill); end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_back_to_back();
      test_error();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
